rice_encoder: RTL

Golomb-Rice entropy coder directly downstream of the LPC analysis stage. It accepts one signed 16-bit residual per handshake and applies the zigzag map. It then emits the Rice codeword (unary quotient plus k-bit remainder, or an escape code) as an MSB-first bitstream packed into bytes with ready/valid backpressure. A flush request pads the final partial byte.

---
 rtl/flac_pkg.sv | 21 ++
 rtl/bit_packer.sv | 66 ++++++
 rtl/rice_encoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/flac_pkg.sv
// Shared definitions for the FLAC residual coding path: the coder state
// encoding, the residual width and the signed-to-unsigned zigzag map.
package flac_pkg;

  localparam int RES_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UNARY = 3'd1,
    STOP  = 3'd2,
    REM   = 3'd3,
    ESC   = 3'd4,
    FLUSH = 3'd5
  } state_e;

  // Folds signed values onto 0,1,2,... as 0,-1,1,-2,...; -32768 lands on 65535.
  function automatic logic [RES_W-1:0] zigzag(input logic signed [RES_W-1:0] r);
    return {r[RES_W-2:0], 1'b0} ^ {RES_W{r[RES_W-1]}};
  endfunction

endpackage

// File: rtl/bit_packer.sv
// MSB-first serial-to-byte packer with a one-byte output register and
// ready/valid backpressure toward the bit source.
module bit_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic       bit_ready,
  output logic       stall,
  output logic       bc_zero,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  // Only seven bits ever wait in the shift register; the eighth goes
  // straight into out_data together with them.
  logic [6:0] sr_q, sr_d;
  logic [2:0] bc_q, bc_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       push;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stall       = (bc_q == 3'd7) && out_valid_q && !out_ready;
    bit_ready   = !stall;
    push        = bit_valid && bit_ready;
    sr_d        = sr_q;
    bc_d        = bc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    if (push) begin
      if (bc_q == 3'd7) begin
        out_data_d  = {sr_q, bit_data};
        out_valid_d = 1'b1;
        bc_d        = 3'd0;
      end else begin
        sr_d = {sr_q[5:0], bit_data};
        bc_d = bc_q + 3'd1;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      bc_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bc_q        <= bc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bc_zero   = (bc_q == 3'd0);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/rice_encoder.sv
// Golomb-Rice coder: zigzag-maps each residual, serialises its unary/remainder
// or escape codeword one bit per cycle into bit_packer, and pads on flush.
module rice_encoder
  import flac_pkg::*;
#(
  parameter int QMAX = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [RES_W-1:0] in_res,
  input  logic [3:0]              rice_k,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic                    flush_done,
  output logic [31:0]             bits_total
);

  localparam logic [7:0] QMAX_B = 8'(QMAX);

  state_e           state_q, state_d;
  logic [RES_W-1:0] u_q, u_d;
  logic [3:0]       k_q, k_d;
  logic [7:0]       tgt_q, tgt_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             esc_q, esc_d;
  logic             flush_pend_q, flush_pend_d;
  logic [31:0]      bits_total_q, bits_total_d;

  logic [RES_W-1:0] u_in, q_in;
  logic             esc_in, accept;
  logic             bit_valid, bit_data, bit_ready, bc_zero;
  logic             stall_unused;

  always_comb begin
    u_in   = zigzag(in_res);
    q_in   = u_in >> rice_k;
    esc_in = (q_in >= 16'(QMAX));
  end

  assign in_ready   = (state_q == IDLE) && !flush_pend_q;
  assign accept     = in_valid && in_ready;
  assign flush_done = (state_q == FLUSH) && bc_zero && !out_valid;

  // tgt_q holds the number of zeros to send; cnt_q counts zeros up in UNARY
  // and indexes remainder/escape bits down in REM and ESC.
  always_comb begin
    state_d   = state_q;
    u_d       = u_q;
    k_d       = k_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    esc_d     = esc_q;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          u_d     = u_in;
          k_d     = rice_k;
          esc_d   = esc_in;
          tgt_d   = esc_in ? QMAX_B : q_in[7:0];
          cnt_d   = '0;
          state_d = (esc_in || (q_in != '0)) ? UNARY : STOP;
        end else if (flush_pend_q) begin
          state_d = FLUSH;
        end
      end
      UNARY: begin
        bit_valid = 1'b1;
        if (bit_ready) begin
          if (cnt_q == tgt_q - 8'd1) begin
            state_d = esc_q ? ESC : STOP;
            cnt_d   = 8'd15;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      STOP: begin
        bit_valid = 1'b1;
        bit_data  = 1'b1;
        if (bit_ready) begin
          if (k_q != 4'd0) begin
            state_d = REM;
            cnt_d   = {4'd0, k_q - 4'd1};
          end else begin
            state_d = IDLE;
          end
        end
      end
      REM, ESC: begin
        bit_valid = 1'b1;
        bit_data  = u_q[cnt_q[3:0]];
        if (bit_ready) begin
          if (cnt_q == 8'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      FLUSH: begin
        bit_valid = !bc_zero;
        if (bc_zero && !out_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad bits emitted in FLUSH are not code bits and stay out of the count.
  always_comb begin
    flush_pend_d = (flush_pend_q && !flush_done) || flush;
    bits_total_d = bits_total_q +
                   {31'd0, bit_valid && bit_ready && (state_q != FLUSH)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      u_q          <= '0;
      k_q          <= '0;
      tgt_q        <= '0;
      cnt_q        <= '0;
      esc_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      bits_total_q <= '0;
    end else begin
      state_q      <= state_d;
      u_q          <= u_d;
      k_q          <= k_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      esc_q        <= esc_d;
      flush_pend_q <= flush_pend_d;
      bits_total_q <= bits_total_d;
    end
  end

  assign bits_total = bits_total_q;

  bit_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .bit_ready (bit_ready),
    .stall     (stall_unused),
    .bc_zero   (bc_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule
